// File: rtl/pep_common_param_pkg.sv
// Shared PEP widths plus the instrumentation-aggregator types and limits.
package pep_common_param_pkg;

    localparam int unsigned PEP_ERROR_W      = 32;
    localparam int unsigned PEP_INFO_W       = 64;
    localparam int unsigned PEP_INC_W        = 16;

    localparam int unsigned RIF_AGG_MAX_SRC  = 8;
    localparam int unsigned RIF_AGG_MAX_PIPE = 4;

    typedef logic [PEP_ERROR_W-1:0] rif_agg_err_t;
    typedef logic [PEP_INFO_W-1:0]  rif_agg_info_t;
    typedef logic [PEP_INC_W-1:0]   rif_agg_inc_t;

endpackage

// File: rtl/hpu_rif_delay_line.sv
// Fixed-depth register delay line with synchronous active-low reset; depth 0 is a wire.
module hpu_rif_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             s_rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = clk ^ s_rst_n;
        assign dout        = din;
    end else begin : g_regs
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk) begin
            if (!s_rst_n) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= din;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/hpu_rif_aggregator.sv
// Merges per-partition error/info/increment vectors into a registered register-interface view
// with sticky errors, new-error irq, optional sticky info and saturating event counters.
module hpu_rif_aggregator
    import pep_common_param_pkg::*;
#(
    parameter int unsigned NB_SRC      = 3,
    parameter int unsigned ERROR_W     = PEP_ERROR_W,
    parameter int unsigned INFO_W      = PEP_INFO_W,
    parameter int unsigned INC_W       = PEP_INC_W,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned IN_PIPE     = 1,
    parameter int unsigned INFO_STICKY = 0,
    localparam int unsigned IDX_W      = (INC_W > 1) ? $clog2(INC_W) : 1
) (
    input  logic                      clk,
    input  logic                      s_rst_n,
    input  logic [NB_SRC*ERROR_W-1:0] src_error,
    input  logic [NB_SRC*INFO_W-1:0]  src_info,
    input  logic [NB_SRC*INC_W-1:0]   src_inc,
    input  logic [ERROR_W-1:0]        err_clr,
    input  logic                      info_clr,
    input  logic                      cnt_clr,
    input  logic [IDX_W-1:0]          cnt_rd_idx,
    output logic [ERROR_W-1:0]        error,
    output logic                      error_irq,
    output logic [INFO_W-1:0]         info,
    output logic [INC_W-1:0]          inc,
    output logic [CNT_W-1:0]          cnt_rd_data,
    output logic [INC_W-1:0]          cnt_sat
);

    localparam int unsigned        VEC_W    = ERROR_W + INFO_W + INC_W;
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]   CNT_NEAR = ~CNT_W'(1);

    if (NB_SRC < 1 || NB_SRC > RIF_AGG_MAX_SRC) begin : g_bad_nb_src
        $fatal(1, "hpu_rif_aggregator: NB_SRC=%0d outside 1..%0d", NB_SRC, RIF_AGG_MAX_SRC);
    end
    if (IN_PIPE > RIF_AGG_MAX_PIPE) begin : g_bad_in_pipe
        $fatal(1, "hpu_rif_aggregator: IN_PIPE=%0d outside 0..%0d", IN_PIPE, RIF_AGG_MAX_PIPE);
    end

    logic [ERROR_W-1:0] or_err;
    logic [INFO_W-1:0]  or_info;
    logic [INC_W-1:0]   or_inc;
    logic [VEC_W-1:0]   stage0_q;
    logic [VEC_W-1:0]   pipe_vec;
    logic [ERROR_W-1:0] merged_err;
    logic [INFO_W-1:0]  merged_info;
    logic [INC_W-1:0]   merged_inc;
    logic [ERROR_W-1:0] error_next;
    logic               irq_next;
    logic [INFO_W-1:0]  info_next;
    logic [CNT_W-1:0]   cnt_q [INC_W];
    logic               rd_idx_ok;

    // OR-reduce across partitions
    always_comb begin
        or_err  = '0;
        or_info = '0;
        or_inc  = '0;
        for (int unsigned s = 0; s < NB_SRC; s++) begin
            or_err  = or_err  | src_error[s*ERROR_W +: ERROR_W];
            or_info = or_info | src_info[s*INFO_W +: INFO_W];
            or_inc  = or_inc  | src_inc[s*INC_W +: INC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            stage0_q <= '0;
        end else begin
            stage0_q <= {or_err, or_info, or_inc};
        end
    end

    hpu_rif_delay_line #(
        .WIDTH (VEC_W),
        .DEPTH (IN_PIPE)
    ) u_delay_line (
        .clk     (clk),
        .s_rst_n (s_rst_n),
        .din     (stage0_q),
        .dout    (pipe_vec)
    );

    assign merged_err  = pipe_vec[INC_W + INFO_W +: ERROR_W];
    assign merged_info = pipe_vec[INC_W +: INFO_W];
    assign merged_inc  = pipe_vec[0 +: INC_W];

    // A set coinciding with its clear wins; irq flags only 0 -> 1 transitions
    always_comb begin
        error_next = (error & ~err_clr) | merged_err;
        irq_next   = |(error_next & ~error);
        info_next  = merged_info;
        if (INFO_STICKY != 0) begin
            info_next = (info_clr ? '0 : info) | merged_info;
        end
    end

    assign rd_idx_ok = 32'(cnt_rd_idx) < INC_W;

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            error       <= '0;
            error_irq   <= 1'b0;
            info        <= '0;
            inc         <= '0;
            cnt_rd_data <= '0;
        end else begin
            error       <= error_next;
            error_irq   <= irq_next;
            info        <= info_next;
            inc         <= merged_inc;
            cnt_rd_data <= rd_idx_ok ? cnt_q[cnt_rd_idx] : '0;
        end
    end

    // Saturating event counters; clear with a coincident event restarts at 1
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            for (int unsigned i = 0; i < INC_W; i++) begin
                cnt_q[i] <= '0;
            end
            cnt_sat <= '0;
        end else begin
            for (int unsigned i = 0; i < INC_W; i++) begin
                if (cnt_clr) begin
                    cnt_q[i]   <= CNT_W'(merged_inc[i]);
                    cnt_sat[i] <= 1'b0;
                end else if (merged_inc[i] && (cnt_q[i] != CNT_MAX)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    if (cnt_q[i] == CNT_NEAR) begin
                        cnt_sat[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
